// File: rtl/sddr_pkg.sv
// ============================================================================
// Module : sddr_pkg
// Brief  : Shared types and helpers for the SDDR read-capture path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sddr_pkg;

  localparam int DATA_BITS    = 16;
  localparam int BURST_LENGTH = 8;

  typedef logic [DATA_BITS-1:0] beat_t;
  typedef beat_t burst_t [8:1];

  // Latencies below 2 cannot be met, because assembly needs the sample register.
  function automatic int clamp_latency(input int lat, input int max_lat);
    if (lat < 2) return 2;
    if (lat > max_lat) return max_lat;
    return lat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sddr_read_capture_if.sv
// ============================================================================
// Module : sddr_read_capture_if
// Brief  : PHY beat / READ timing / burst pop bundle for sddr_read_capture.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface sddr_read_capture_if
  import sddr_pkg::*;
#(
  parameter int MAX_LATENCY = 31
) ();

  localparam int LW = $clog2(MAX_LATENCY + 1);

  logic [BURST_LENGTH*DATA_BITS-1:0] phy_dq_i;
  logic                              rd_issue_i;
  logic [LW-1:0]                     rd_latency_i;
  logic [2:0]                        rd_slip_i;
  logic [BURST_LENGTH*DATA_BITS-1:0] rd_data_o;
  logic                              rd_valid_o;
  logic                              rd_ready_i;
  logic                              rd_busy_o;
  logic                              rd_overflow_o;
  logic                              calib_match_o;
  logic [BURST_LENGTH*DATA_BITS-1:0] calib_pattern_i;

  modport slave (
    input  phy_dq_i, rd_issue_i, rd_latency_i, rd_slip_i, rd_ready_i, calib_pattern_i,
    output rd_data_o, rd_valid_o, rd_busy_o, rd_overflow_o, calib_match_o
  );

  modport master (
    output phy_dq_i, rd_issue_i, rd_latency_i, rd_slip_i, rd_ready_i, calib_pattern_i,
    input  rd_data_o, rd_valid_o, rd_busy_o, rd_overflow_o, calib_match_o
  );

endinterface

`default_nettype wire

// File: rtl/sddr_burst_fifo.sv
// ============================================================================
// Module : sddr_burst_fifo
// Brief  : Small FIFO of 8-beat bursts with sticky overflow flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sddr_burst_fifo
  import sddr_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic   clk,
  input  wire logic   rst,
  input  wire logic   push,
  input  burst_t      push_data,
  output logic        pop_valid,
  input  wire logic   pop_ready,
  output burst_t      pop_data,
  output logic        full,
  output logic        overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  burst_t      r_mem [FIFO_DEPTH];
  logic        r_overflow;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = ~w_empty & pop_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_push    = push & (~full | w_pop);
  assign pop_valid = ~w_empty;
  assign pop_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign overflow  = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '{default: '0};
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr[AW-1:0]] <= push_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (push & full & ~w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sddr_read_capture.sv
// ============================================================================
// Module : sddr_read_capture
// Brief  : DDR3 PHY read back end: latency pipe, beat-slip alignment, burst FIFO.
//          Optional read-training compare enabled by SDDR_READ_CALIB_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sddr_read_capture
  import sddr_pkg::*;
#(
  parameter int MAX_LATENCY = 31,
  parameter int FIFO_DEPTH  = 4
) (
  input  wire logic            in_ddr_clock_i,
  input  wire logic            in_reset_i,
  sddr_read_capture_if.slave   bus
);

  localparam int              PW    = MAX_LATENCY + 1;
  localparam logic [PW-1:0]   c_one = PW'(1);

  logic [PW-1:0] r_pipe;
  logic          r_asm;
  burst_t        r_prev;
  burst_t        w_cur;
  burst_t        w_burst;
  burst_t        w_head;
  logic [PW-1:0] w_set;
  int            w_lat;
  logic          w_unused_full;

  for (genvar k = 1; k <= BURST_LENGTH; k++) begin : g_beats
    assign w_cur[k] = bus.phy_dq_i[k*DATA_BITS-1 -: DATA_BITS];
    assign bus.rd_data_o[k*DATA_BITS-1 -: DATA_BITS] = w_head[k];
  end

  // Marker placed one below L so bit 0 is reached exactly L cycles after issue.
  always_comb begin
    w_lat = clamp_latency(int'(bus.rd_latency_i), MAX_LATENCY);
    w_set = '0;
    if (bus.rd_issue_i) begin
      w_set = c_one << (w_lat - 1);
    end
  end

  always_ff @(posedge in_ddr_clock_i or posedge in_reset_i) begin
    if (in_reset_i) begin
      r_pipe <= '0;
      r_asm  <= 1'b0;
      r_prev <= '{default: '0};
    end else begin
      r_pipe <= (r_pipe >> 1) | w_set;
      r_asm  <= r_pipe[0];
      r_prev <= w_cur;
    end
  end

  // Window is {previous beats 1..8, current beats 1..8}; burst starts at slip+1.
  always_comb begin
    logic [3:0] j;
    logic [3:0] jb;
    for (int k = 1; k <= BURST_LENGTH; k++) begin
      j  = 4'(k) + {1'b0, bus.rd_slip_i};
      jb = j - 4'd8;
      if (j <= 4'd8) begin
        w_burst[k] = r_prev[j];
      end else begin
        w_burst[k] = w_cur[jb];
      end
    end
  end

  assign bus.rd_busy_o = (|r_pipe) | r_asm;

  sddr_burst_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (in_ddr_clock_i),
    .rst       (in_reset_i),
    .push      (r_asm),
    .push_data (w_burst),
    .pop_valid (bus.rd_valid_o),
    .pop_ready (bus.rd_ready_i),
    .pop_data  (w_head),
    .full      (w_unused_full),
    .overflow  (bus.rd_overflow_o)
  );

`ifdef SDDR_READ_CALIB_EN
  logic [BURST_LENGTH*DATA_BITS-1:0] w_burst_flat;
  logic                              r_calib_match;

  for (genvar k = 1; k <= BURST_LENGTH; k++) begin : g_calib_flat
    assign w_burst_flat[k*DATA_BITS-1 -: DATA_BITS] = w_burst[k];
  end

  always_ff @(posedge in_ddr_clock_i or posedge in_reset_i) begin
    if (in_reset_i) begin
      r_calib_match <= 1'b0;
    end else begin
      r_calib_match <= r_asm && (w_burst_flat == bus.calib_pattern_i);
    end
  end

  assign bus.calib_match_o = r_calib_match;
`else
  logic w_unused_calib;
  assign w_unused_calib    = ^bus.calib_pattern_i;
  assign bus.calib_match_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sddr_read_capture.sv
// ============================================================================
// Module : tb_sddr_read_capture
// Brief  : Scoreboard bench for sddr_read_capture (calib checks with SDDR_READ_CALIB_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sddr_read_capture;
  import sddr_pkg::*;

  localparam int DW = BURST_LENGTH * DATA_BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sddr_read_capture_if #(.MAX_LATENCY(31)) bus ();

  sddr_read_capture #(
    .MAX_LATENCY (31),
    .FIFO_DEPTH  (4)
  ) dut (
    .in_ddr_clock_i (clk),
    .in_reset_i     (rst),
    .bus            (bus)
  );

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  int            lat    = 5;
  int            slip   = 0;
  logic          ready  = 1'b1;
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Beat k of cycle n carries the cycle number and beat index.
  function automatic logic [DW-1:0] gen(input int n);
    logic [31:0]   nn;
    logic [DW-1:0] r;
    nn = n;
    for (int k = 1; k <= 8; k++) r[k*16-1 -: 16] = {nn[11:0], 4'(k)};
    return r;
  endfunction

  function automatic int clamp_model(input int l);
    return (l < 2) ? 2 : ((l > 31) ? 31 : l);
  endfunction

  function automatic logic [DW-1:0] model_burst(input int c, input int l, input int s);
    logic [DW-1:0] a, b, r;
    int lc, j;
    lc = clamp_model(l);
    a  = gen(c + lc);
    b  = gen(c + lc + 1);
    for (int k = 1; k <= 8; k++) begin
      j = k + s;
      if (j <= 8) r[k*16-1 -: 16] = a[j*16-1 -: 16];
      else        r[k*16-1 -: 16] = b[(j-8)*16-1 -: 16];
    end
    return r;
  endfunction

  task automatic step(input logic iss, input logic keep);
    @(posedge clk);
    #1;
    cyc++;
    bus.phy_dq_i     = gen(cyc);
    bus.rd_issue_i   = iss;
    bus.rd_latency_i = 5'(lat);
    bus.rd_slip_i    = 3'(slip);
    bus.rd_ready_i   = ready;
    if (iss && keep) exp_q.push_back(model_burst(cyc, lat, slip));
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rd_valid_o && bus.rd_ready_i) begin
      if (exp_q.size() == 0) check("unexp_pop", DW'(bus.rd_valid_o), '0);
      else                   check("burst", bus.rd_data_o, exp_q.pop_front());
    end
  end

  initial begin
    bus.phy_dq_i        = '0;
    bus.rd_issue_i      = 1'b0;
    bus.rd_latency_i    = '0;
    bus.rd_slip_i       = '0;
    bus.rd_ready_i      = 1'b1;
    bus.calib_pattern_i = '0;

    repeat (3) step(0, 0);
    check("rst_valid", DW'(bus.rd_valid_o), '0);
    check("rst_busy", DW'(bus.rd_busy_o), '0);
    check("rst_ovf", DW'(bus.rd_overflow_o), '0);
    check("rst_data", bus.rd_data_o, '0);
    check("rst_calib", DW'(bus.calib_match_o), '0);
    rst = 1'b0;
    step(0, 0);

    // Single read, L=5, slip 0: valid in cycle L+2, busy drops the same cycle.
    lat = 5; slip = 0; ready = 1'b1;
    step(1, 1);
    for (int i = 1; i <= 9; i++) begin
      step(0, 0);
      check("t1_valid", DW'(bus.rd_valid_o), DW'(i == 7));
      check("t1_busy", DW'(bus.rd_busy_o), DW'(i <= 6));
    end

    // Slip 3 takes beats 4..8 of the first cycle and 1..3 of the next.
    slip = 3;
    step(1, 1);
    repeat (9) step(0, 0);

    // Back-to-back reads at L=4.
    lat = 4; slip = 0;
    repeat (4) step(1, 1);
    for (int i = 4; i <= 10; i++) begin
      step(0, 0);
      check("t3_valid", DW'(bus.rd_valid_o), DW'(i >= 6 && i <= 9));
    end
    check("t3_ovf", DW'(bus.rd_overflow_o), '0);

    // Five reads into a 4-deep FIFO with no consumer: the fifth is dropped.
    ready = 1'b0; lat = 3;
    repeat (4) step(1, 1);
    step(1, 0);
    repeat (10) step(0, 0);
    check("t4_ovf", DW'(bus.rd_overflow_o), DW'(1));
    check("t4_valid", DW'(bus.rd_valid_o), DW'(1));
    ready = 1'b1;
    repeat (8) step(0, 0);
    check("t4_drained", DW'(exp_q.size()), '0);
    check("t4_empty", DW'(bus.rd_valid_o), '0);

    // Reset with two reads in flight: nothing may surface afterwards.
    lat = 6;
    step(1, 0);
    step(1, 0);
    step(0, 0);
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0);
      check("t5_valid", DW'(bus.rd_valid_o), '0);
    end
    check("t5_busy", DW'(bus.rd_busy_o), '0);
    check("t5_ovf_clr", DW'(bus.rd_overflow_o), '0);
    check("t5_data", bus.rd_data_o, '0);

    // Full FIFO: push and pop land in the same cycle, nothing lost.
    ready = 1'b0; lat = 3;
    repeat (4) step(1, 1);
    repeat (6) step(0, 0);
    step(1, 1);
    repeat (3) step(0, 0);
    ready = 1'b1;
    step(0, 0);
    check("t6_valid", DW'(bus.rd_valid_o), DW'(1));
    repeat (8) step(0, 0);
    check("t6_ovf", DW'(bus.rd_overflow_o), '0);
    check("t6_drained", DW'(exp_q.size()), '0);

    // Latency 0 is clamped to 2; latency 31 is the top of range.
    lat = 0;
    step(1, 1);
    for (int i = 1; i <= 6; i++) begin
      step(0, 0);
      check("t7_l0_valid", DW'(bus.rd_valid_o), DW'(i == 4));
    end
    lat = 31;
    step(1, 1);
    for (int i = 1; i <= 35; i++) begin
      step(0, 0);
      check("t7_l31_valid", DW'(bus.rd_valid_o), DW'(i == 33));
    end

`ifdef SDDR_READ_CALIB_EN
    lat = 4; slip = 2;
    bus.calib_pattern_i = model_burst(cyc + 1, lat, slip);
    step(1, 1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0);
      check("calib_hit", DW'(bus.calib_match_o), DW'(i == 6));
    end
    bus.calib_pattern_i = model_burst(cyc + 1, lat, slip) ^ DW'(1);
    step(1, 1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 0);
      check("calib_miss", DW'(bus.calib_match_o), '0);
    end
`endif

    repeat (4) step(0, 0);
    check("final_q", DW'(exp_q.size()), '0);
    check("final_ovf", DW'(bus.rd_overflow_o), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
